// File: rtl/g15_pkg.sv
// Shared drum timing constants and the transfer-window FSM state encoding.
package g15_pkg;

  localparam int unsigned BITS_PER_WORD  = 29;
  localparam int unsigned WORDS_PER_LINE = 108;
  localparam int unsigned LINE_BITS      = BITS_PER_WORD * WORDS_PER_LINE;

  localparam int unsigned BIT_W   = 5;
  localparam int unsigned WORD_W  = 7;
  localparam int unsigned PHASE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } drum_state_e;

endpackage

// File: rtl/drum_timing_if.sv
// Request and timing/status bundle between a line controller and drum_timing.
interface drum_timing_if;
  import g15_pkg::*;

  logic               START;
  logic               BLOCK;
  logic [WORD_W-1:0]  CMD_T;
  logic [BIT_W-1:0]   BIT_CNT;
  logic [WORD_W-1:0]  WORD_CNT;
  logic               T0;
  logic               T29;
  logic               L107;
  logic [PHASE_W-1:0] PHASE;
  logic               TR;
  logic               BUSY;
  logic               DONE;
  logic               ERR;

  modport master (
    output START, BLOCK, CMD_T,
    input  BIT_CNT, WORD_CNT, T0, T29, L107, PHASE, TR, BUSY, DONE, ERR
  );

  modport slave (
    input  START, BLOCK, CMD_T,
    output BIT_CNT, WORD_CNT, T0, T29, L107, PHASE, TR, BUSY, DONE, ERR
  );

endinterface

// File: rtl/drum_timing.sv
// Free-running drum bit/word counters plus a transfer-window FSM that opens
// the TR gate for one word (single) or a run of words ending at T (block).
module drum_timing
  import g15_pkg::*;
(
  input  logic          CLOCK,
  input  logic          rst,
  drum_timing_if.slave  bus
);

  logic [BIT_W-1:0]  bit_q,  bit_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0] t_q;
  logic              block_q;
  logic              err_q;
  drum_state_e       state_q;

  logic              last_bit_c;
  logic              win_end_c;
  logic              cmd_ok_c;

  // Next counter values; the FSM looks ahead so TR lines up with bit 0.
  always_comb begin
    bit_d  = bit_q + 1'b1;
    word_d = word_q;
    if (last_bit_c) begin
      bit_d  = '0;
      word_d = (word_q == WORD_W'(WORDS_PER_LINE - 1)) ? '0 : word_q + 1'b1;
    end
  end

  assign last_bit_c = (bit_q == BIT_W'(BITS_PER_WORD - 1));
  assign win_end_c  = (state_q == ST_XFER) && last_bit_c && (word_q == t_q);
  assign cmd_ok_c   = (bus.CMD_T < WORD_W'(WORDS_PER_LINE));

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      bit_q   <= '0;
      word_q  <= '0;
      t_q     <= '0;
      block_q <= 1'b0;
      err_q   <= 1'b0;
      state_q <= ST_IDLE;
    end else begin
      bit_q  <= bit_d;
      word_q <= word_d;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.START) begin
            if (cmd_ok_c) begin
              t_q     <= bus.CMD_T;
              block_q <= bus.BLOCK;
              state_q <= ST_WAIT;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if ((bit_d == '0) && (block_q || (word_d == t_q))) begin
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (win_end_c) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.BIT_CNT  = bit_q;
  assign bus.WORD_CNT = word_q;
  assign bus.T0       = (bit_q == '0);
  assign bus.T29      = last_bit_c;
  assign bus.L107     = (word_q == WORD_W'(WORDS_PER_LINE - 1));
  assign bus.PHASE    = word_q[PHASE_W-1:0];
  assign bus.TR       = (state_q == ST_XFER);
  assign bus.BUSY     = (state_q != ST_IDLE);
  assign bus.DONE     = win_end_c;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_drum_timing.sv
// Directed bench for drum_timing: free-run counter checks, a table of
// transfer windows, and hand sequences for ignore/reset/back-to-back cases.
module tb_drum_timing;
  import g15_pkg::*;

  logic CLOCK = 1'b0;
  logic rst;

  drum_timing_if bus ();

  drum_timing dut (
    .CLOCK (CLOCK),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 CLOCK = ~CLOCK;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic blk;
    int   sw;
    int   sb;
    int   t;
    logic err;
    int   fw;
    int   delay;
    int   len;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic goto_pos(input int w, input int b);
    int n;
    n = 0;
    while (!(int'(bus.WORD_CNT) == w && int'(bus.BIT_CNT) == b) && n < 3200) begin
      step();
      n++;
    end
    chk("goto_timeout", (n < 3200) ? 1 : 0, 1);
  endtask

  task automatic start_req(input logic blk, input int t);
    bus.START = 1'b1;
    bus.BLOCK = blk;
    bus.CMD_T = WORD_W'(t);
    step();
    bus.START = 1'b0;
  endtask

  // Observes from the current cycle (k=1) until TR has risen and fallen.
  task automatic measure(input int limit, output int d, output int fw, output int fb,
                         output int len, output int dn, output int dw, output int db,
                         output int e1, output int en, output int b1, output int ph,
                         output int endbusy);
    d = -1; fw = -1; fb = -1; len = 0; dn = 0; dw = -1; db = -1;
    e1 = 0; en = 0; b1 = 0; ph = -1; endbusy = -1;
    for (int k = 1; k <= limit; k++) begin
      if (k == 1) begin
        e1 = int'(bus.ERR);
        b1 = int'(bus.BUSY);
      end
      if (bus.ERR) en++;
      if (bus.TR) begin
        if (d < 0) begin
          d  = k;
          fw = int'(bus.WORD_CNT);
          fb = int'(bus.BIT_CNT);
          ph = int'(bus.PHASE);
        end
        len++;
      end
      if (bus.DONE) begin
        dn++;
        dw = int'(bus.WORD_CNT);
        db = int'(bus.BIT_CNT);
      end
      if (d >= 0 && !bus.TR) begin
        endbusy = int'(bus.BUSY);
        break;
      end
      step();
    end
  endtask

  initial begin
    int d, fw, fb, len, dn, dw, db, e1, en, b1, ph, eb;
    int t0n, t29n, l107n, l107r1, cnt_bad, ph_bad, pos;

    vecs[0] = '{1'b0,   5,  3,  10, 1'b0,  10,  142,   29};
    vecs[1] = '{1'b1, 105,  0,   2, 1'b0, 106,   29,  145};
    vecs[2] = '{1'b1,  40, 14,  40, 1'b0,  41,   15, 3132};
    vecs[3] = '{1'b0,  40, 14,  40, 1'b0,  40, 3118,   29};
    vecs[4] = '{1'b1,  19, 10,  20, 1'b0,  20,   19,   29};
    vecs[5] = '{1'b0,   3,  0, 120, 1'b1,  -1,   -1,    0};
    vecs[6] = '{1'b0,   0,  0, 107, 1'b0, 107, 3103,   29};
    vecs[7] = '{1'b0, 106,  5,   0, 1'b0,   0,   53,   29};
    vecs[8] = '{1'b1, 106, 28, 107, 1'b0,   0,   30, 3132};
    vecs[9] = '{1'b0,  50,  7, 108, 1'b1,  -1,   -1,    0};

    rst = 1'b1;
    bus.START = 1'b0;
    bus.BLOCK = 1'b0;
    bus.CMD_T = '0;
    step();
    step();
    rst = 1'b0;

    chk("rst_bit",  int'(bus.BIT_CNT), 0);
    chk("rst_word", int'(bus.WORD_CNT), 0);
    chk("rst_tr",   int'(bus.TR), 0);
    chk("rst_busy", int'(bus.BUSY), 0);
    chk("rst_done", int'(bus.DONE), 0);
    chk("rst_err",  int'(bus.ERR), 0);
    chk("rst_t0",   int'(bus.T0), 1);

    // Cycle 0 is the observation right after reset; cycle i sits at position i mod 3132.
    t0n = 0; t29n = 0; l107n = 0; l107r1 = 0; cnt_bad = 0; ph_bad = 0;
    for (int i = 1; i <= 6264; i++) begin
      step();
      pos = i % 3132;
      if (int'(bus.BIT_CNT) != pos % 29 || int'(bus.WORD_CNT) != pos / 29) cnt_bad++;
      if (int'(bus.PHASE) != (pos / 29) % 4) ph_bad++;
      if (bus.T0) t0n++;
      if (bus.T29) t29n++;
      if (bus.L107) begin
        l107n++;
        if (i <= 3132) l107r1++;
      end
      if (i == 3131) chk("wrap_pre_word", int'(bus.WORD_CNT), 107);
      if (i == 3132) chk("wrap1_word", int'(bus.WORD_CNT), 0);
      if (i == 6264) chk("wrap2_word", int'(bus.WORD_CNT), 0);
    end
    chk("free_cnt_model", cnt_bad, 0);
    chk("free_phase",     ph_bad, 0);
    chk("free_t0",        t0n, 216);
    chk("free_t29",       t29n, 216);
    chk("free_l107_rev",  l107r1, 29);
    chk("free_l107_all",  l107n, 58);

    foreach (vecs[v]) begin
      goto_pos(vecs[v].sw, vecs[v].sb);
      start_req(vecs[v].blk, vecs[v].t);
      measure(vecs[v].err ? 200 : vecs[v].delay + vecs[v].len + 5,
              d, fw, fb, len, dn, dw, db, e1, en, b1, ph, eb);
      chk($sformatf("v%0d_err1", v),  e1, int'(vecs[v].err));
      chk($sformatf("v%0d_errn", v),  en, int'(vecs[v].err));
      chk($sformatf("v%0d_busy1", v), b1, int'(!vecs[v].err));
      chk($sformatf("v%0d_delay", v), d, vecs[v].delay);
      chk($sformatf("v%0d_len", v),   len, vecs[v].len);
      chk($sformatf("v%0d_done", v),  dn, vecs[v].err ? 0 : 1);
      if (!vecs[v].err) begin
        chk($sformatf("v%0d_fword", v), fw, vecs[v].fw);
        chk($sformatf("v%0d_fbit", v),  fb, 0);
        chk($sformatf("v%0d_phase", v), ph, vecs[v].fw % 4);
        chk($sformatf("v%0d_dword", v), dw, vecs[v].t);
        chk($sformatf("v%0d_dbit", v),  db, 28);
        chk($sformatf("v%0d_endbusy", v), eb, 0);
      end
    end

    // START during XFER must not disturb the open window.
    goto_pos(5, 3);
    start_req(1'b0, 10);
    goto_pos(10, 5);
    chk("ign_tr_before", int'(bus.TR), 1);
    start_req(1'b1, 50);
    measure(60, d, fw, fb, len, dn, dw, db, e1, en, b1, ph, eb);
    chk("ign_err",     en, 0);
    chk("ign_len",     len, 23);
    chk("ign_dword",   dw, 10);
    chk("ign_done",    dn, 1);
    chk("ign_endbusy", eb, 0);

    // Back-to-back: a START on the cycle after DONE is accepted.
    goto_pos(0, 0);
    start_req(1'b0, 12);
    dn = 0;
    for (int k = 0; k < 500 && dn == 0; k++) begin
      if (bus.DONE) dn = 1;
      else step();
    end
    chk("b2b_first_done", dn, 1);
    step();
    start_req(1'b1, 14);
    measure(80, d, fw, fb, len, dn, dw, db, e1, en, b1, ph, eb);
    chk("b2b_busy",  b1, 1);
    chk("b2b_delay", d, 29);
    chk("b2b_fword", fw, 14);
    chk("b2b_len",   len, 29);
    chk("b2b_done",  dn, 1);

    // Reset in the middle of an XFER window.
    goto_pos(0, 0);
    start_req(1'b0, 7);
    goto_pos(7, 10);
    chk("rx_tr_before", int'(bus.TR), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rx_tr",   int'(bus.TR), 0);
    chk("rx_done", int'(bus.DONE), 0);
    chk("rx_busy", int'(bus.BUSY), 0);
    chk("rx_bit",  int'(bus.BIT_CNT), 0);
    chk("rx_word", int'(bus.WORD_CNT), 0);
    dn = 0; len = 0;
    for (int k = 0; k < 400; k++) begin
      step();
      if (bus.DONE) dn++;
      if (bus.TR) len++;
    end
    chk("rx_after_done", dn, 0);
    chk("rx_after_tr",   len, 0);

    // Reset wins over a START on the same edge.
    rst = 1'b1;
    bus.START = 1'b1;
    bus.BLOCK = 1'b1;
    bus.CMD_T = WORD_W'(5);
    step();
    rst = 1'b0;
    bus.START = 1'b0;
    chk("rs_busy0", int'(bus.BUSY), 0);
    step();
    chk("rs_busy1", int'(bus.BUSY), 0);
    chk("rs_err",   int'(bus.ERR), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drum_timing.md
DRUM_TIMING -- requirements
Module: drum_timing

Interface
REQ-001 SHALL expose CLOCK  input  1  system clock; one CLOCK = one drum bit time.
REQ-002 SHALL expose rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL expose START  input  1  one-cycle request to begin a transfer window.
REQ-004 SHALL expose BLOCK  input  1  sampled with START; 0 = single word at T, 1 = block transfer ending at T.
REQ-005 SHALL expose CMD_T  input  7  sampled with START; target word time, valid range 0..107.
REQ-006 SHALL expose BIT_CNT  output  5  bit position in the current word, 0..28.
REQ-007 SHALL expose WORD_CNT  output  7  word time under the heads, 0..107.
REQ-008 SHALL expose T0  output  1  high when BIT_CNT==0.
REQ-009 SHALL expose T29  output  1  high when BIT_CNT==28.
REQ-010 SHALL expose L107  output  1  high when WORD_CNT==107.
REQ-011 SHALL expose PHASE  output  2  WORD_CNT modulo 4, for short-line alignment.
REQ-012 SHALL expose TR  output  1  transfer gate that qualifies line write and read enables.
REQ-013 SHALL expose BUSY  output  1  high in WAIT or XFER.
REQ-014 SHALL expose DONE  output  1  one-cycle pulse on the final bit of a window.
REQ-015 SHALL expose ERR  output  1  one-cycle pulse when a START is rejected.

Function
REQ-016 BIT_CNT SHALL increment every CLOCK and wrap from 28 to 0.
REQ-017 WORD_CNT SHALL increment on the cycle after BIT_CNT==28 and wrap from 107 to 0.
  - Revolution period is exactly 3132 cycles, matching a 3132-bit drum track.
REQ-018 T0, T29, L107 and PHASE SHALL be combinational decodes of the registered counters, with zero latency.
REQ-019 The FSM SHALL have three states: IDLE, WAIT and XFER.
REQ-020 In IDLE, START with CMD_T<=107 SHALL latch CMD_T and BLOCK and enter WAIT on the next cycle.
REQ-021 START with CMD_T>=108 SHALL pulse ERR on the next cycle and leave the FSM in IDLE.
REQ-022 START while BUSY SHALL be ignored, with no ERR and no change to the latched T or BLOCK.
REQ-023 Single mode: WAIT SHALL go to XFER at the first word boundary (BIT_CNT==0) where WORD_CNT equals the latched T.
  - If START arrives mid-word T, the window waits for the next revolution.
REQ-024 Block mode: WAIT SHALL go to XFER at the first word boundary after START.
REQ-025 TR SHALL be high exactly on the cycles when the FSM is in XFER (a registered state decode), aligned to BIT_CNT 0..28.
REQ-026 XFER SHALL end after the BIT_CNT==28 cycle of word T.
  - On that cycle DONE SHALL pulse and the next state SHALL be IDLE.
REQ-027 Block mode where the first transferred word equals T SHALL yield a one-word window.
REQ-028 Block mode where START falls inside word T SHALL yield a 108-word window, including the wrap 107->0.
REQ-029 A new START SHALL be accepted on the cycle after DONE.
REQ-030 The counters SHALL run free and SHALL be unaffected by FSM activity.

Reset
REQ-031 When rst=1 at a CLOCK edge, the block SHALL set BIT_CNT=0, WORD_CNT=0, FSM=IDLE, and TR, BUSY, DONE and ERR to 0.
REQ-032 Reset during WAIT or XFER SHALL abort the window with no DONE pulse; TR SHALL be 0 on the first cycle after the reset edge.
REQ-033 rst SHALL override a START sampled on the same edge.

Structure
REQ-034 Constants BITS_PER_WORD=29, WORDS_PER_LINE=108 and LINE_BITS=3132, plus the FSM state enum, SHALL live in shared package g15_pkg.
REQ-035 The block SHALL be a single module with no sub-modules.
  - The counters and FSM are inline; output T/BLOCK holding registers are local.
REQ-036 Outputs SHALL be registers or decodes of registers only, with no combinational path from START to TR.

Verification
REQ-037 Reset then free-run for 6264 cycles -> WORD_CNT returns to 0 at cycles 3132 and 6264; T0 pulses 216 times; L107 is high for 29 cycles per revolution.
REQ-038 Single mode, START at WORD_CNT=5, BIT_CNT=3, CMD_T=10 -> TR high for 29 cycles starting at WORD_CNT=10, BIT_CNT=0; DONE pulses at WORD_CNT=10, BIT_CNT=28.
REQ-039 Block mode, START at WORD_CNT=105, CMD_T=2 -> TR runs from word 106 through word 2 (5 words, 145 cycles, across the wrap); one DONE pulse.
REQ-040 Block mode, START mid-word 40, CMD_T=40 -> TR high for 3132 cycles; single mode with the same timing -> TR waits until the next revolution's word 40.
REQ-041 START with CMD_T=120 -> ERR pulses for one cycle, BUSY stays 0; a START during XFER -> ignored, window unchanged.
REQ-042 rst asserted during XFER at word 7 -> TR is 0 the next cycle, no DONE, counters are 0.
